// File: rtl/ula.sv
// ---------------------------------------------------------------------------
// ula - 8-bit arithmetic/logic unit for the Redux-V datapath.
//
// Combines two register operands with one of ten operations. The result and
// its zero flag are captured on every rising clock edge, which gives one
// cycle of latency. There is no enable and no handshake, so a new result is
// taken on every edge.
//
// Ports
//   clk     in   1  clock; all state changes on the rising edge
//   rst_n   in   1  synchronous active-low reset (S <= 0, ZERO <= 1)
//   A       in   8  operand R[A], unsigned
//   B       in   8  operand R[B], unsigned; also the shift/rotate amount
//   Seletor in   4  operation code (0..9 defined, 10..15 yield zero)
//   S       out  8  registered result
//   ZERO    out  1  registered flag, 1 when S == 8'h00
//
// Operation codes
//   0 NOT  ~A            5 SUB  (A - B) mod 256
//   1 AND  A & B         6 SLR  A << B, B >= 8 -> 0
//   2 OR   A | B         7 SRR  A >> B, B >= 8 -> 0
//   3 XOR  A ^ B         8 MUL  (A * B) mod 256
//   4 ADD  (A + B) mod 256   9 ROL  rotate A left by B[2:0]
// ---------------------------------------------------------------------------
module ula (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic [3:0] Seletor,
  output logic [7:0] S,
  output logic       ZERO
);

  localparam logic [3:0] OP_NOT = 4'd0;
  localparam logic [3:0] OP_AND = 4'd1;
  localparam logic [3:0] OP_OR  = 4'd2;
  localparam logic [3:0] OP_XOR = 4'd3;
  localparam logic [3:0] OP_ADD = 4'd4;
  localparam logic [3:0] OP_SUB = 4'd5;
  localparam logic [3:0] OP_SLR = 4'd6;
  localparam logic [3:0] OP_SRR = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_ROL = 4'd9;

  logic [7:0]  w_sum;
  logic [7:0]  w_diff;
  logic [15:0] w_prod;
  logic [15:0] w_rol_wide;
  logic [7:0]  w_rol;
  logic        w_big_shift;
  logic [7:0]  w_shl;
  logic [7:0]  w_shr;
  logic [7:0]  w_result;

  logic [7:0]  r_s;
  logic        r_zero;

  // Carry and borrow are simply dropped by the 8-bit destination width.
  assign w_sum  = A + B;
  assign w_diff = A - B;

  // Full 16-bit product; only the low byte is used.
  assign w_prod = {8'h00, A} * {8'h00, B};

  // Any amount with a bit set above bit 2 pushes every bit of A out.
  assign w_big_shift = |B[7:3];
  assign w_shl       = w_big_shift ? 8'h00 : (A << B[2:0]);
  assign w_shr       = w_big_shift ? 8'h00 : (A >> B[2:0]);

  // Rotate by B mod 8: shift a doubled copy of A and keep the upper byte,
  // so the bits leaving the top re-enter at the bottom.
  assign w_rol_wide = {A, A} << B[2:0];
  assign w_rol      = w_rol_wide[15:8];

  always_comb begin
    w_result = 8'h00;
    case (Seletor)
      OP_NOT:  w_result = ~A;
      OP_AND:  w_result = A & B;
      OP_OR:   w_result = A | B;
      OP_XOR:  w_result = A ^ B;
      OP_ADD:  w_result = w_sum;
      OP_SUB:  w_result = w_diff;
      OP_SLR:  w_result = w_shl;
      OP_SRR:  w_result = w_shr;
      OP_MUL:  w_result = w_prod[7:0];
      OP_ROL:  w_result = w_rol;
      default: w_result = 8'h00;
    endcase
  end

  // ZERO is taken from the value being captured now, so it always matches
  // the S presented alongside it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s    <= 8'h00;
      r_zero <= 1'b1;
    end else begin
      r_s    <= w_result;
      r_zero <= (w_result == 8'h00);
    end
  end

  assign S    = r_s;
  assign ZERO = r_zero;

endmodule

// File: tb/tb_ula.sv
// ---------------------------------------------------------------------------
// tb_ula - self-checking bench for ula.
//
// Inputs change on the falling edge. At each rising edge a reference model
// computes the result from the inputs the DUT is sampling and pushes it into
// exp_q. At each falling edge the compare process pops one entry and checks
// {ZERO, S}. Literal expectations from the directed cases pin the model.
// ---------------------------------------------------------------------------
module tb_ula;

  logic       clk;
  logic       rst_n;
  logic [7:0] A;
  logic [7:0] B;
  logic [3:0] Seletor;
  logic [7:0] S;
  logic       ZERO;

  int tests;
  int fails;

  logic [8:0] exp_q[$];

  ula dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .A       (A),
    .B       (B),
    .Seletor (Seletor),
    .S       (S),
    .ZERO    (ZERO)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  function automatic int ref_alu(input int op, input int a, input int b);
    int r;
    case (op)
      0: ref_alu = 255 - a;
      1: ref_alu = a & b;
      2: ref_alu = a | b;
      3: ref_alu = a ^ b;
      4: ref_alu = (a + b) % 256;
      5: ref_alu = (a - b + 256) % 256;
      6: ref_alu = (b >= 8) ? 0 : (a * (1 << b)) % 256;
      7: ref_alu = (b >= 8) ? 0 : a / (1 << b);
      8: ref_alu = (a * b) % 256;
      9: begin
        r = b % 8;
        ref_alu = ((a * (1 << r)) + (a / (1 << (8 - r)))) % 256;
      end
      default: ref_alu = 0;
    endcase
  endfunction

  always @(posedge clk) begin
    int v;
    if (!rst_n) begin
      exp_q.push_back({1'b1, 8'h00});
    end else begin
      v = ref_alu(int'(Seletor), int'(A), int'(B));
      exp_q.push_back({(v == 0), v[7:0]});
    end
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [8:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if ({ZERO, S} !== e) begin
        fails++;
        $display("FAIL model t=%0t got S=%02h ZERO=%0b want S=%02h ZERO=%0b",
                 $time, S, ZERO, e[7:0], e[8]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    Seletor = op;
    A = a;
    B = b;
    @(negedge clk);
  endtask

  task automatic check_lit(input string name, input logic [7:0] es, input logic ez);
    tests++;
    if (S !== es || ZERO !== ez) begin
      fails++;
      $display("FAIL %s got S=%02h ZERO=%0b want S=%02h ZERO=%0b",
               name, S, ZERO, es, ez);
    end
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] sweep_exp [10];

  initial begin
    logic [7:0] held;
    tests = 0;
    fails = 0;
    sweep_exp[0] = 8'b10111000;
    sweep_exp[1] = 8'b00000010;
    sweep_exp[2] = 8'b01000111;
    sweep_exp[3] = 8'b01000101;
    sweep_exp[4] = 8'b01001001;
    sweep_exp[5] = 8'b01000101;
    sweep_exp[6] = 8'b00011100;
    sweep_exp[7] = 8'b00010001;
    sweep_exp[8] = 8'b10001110;
    sweep_exp[9] = 8'b00011101;

    // reset with a live ADD on the inputs
    rst_n = 1'b0;
    do_op(4'd4, 8'hFF, 8'hFF);
    check_lit("reset1", 8'h00, 1'b1);
    do_op(4'd4, 8'hFF, 8'hFF);
    check_lit("reset2", 8'h00, 1'b1);
    rst_n = 1'b1;
    do_op(4'd4, 8'hFF, 8'hFF);
    check_lit("reset_release_add", 8'hFE, 1'b0);

    // opcode sweep, back to back
    for (int i = 0; i < 10; i++) begin
      do_op(i[3:0], 8'b01000111, 8'b00000010);
      check_lit($sformatf("sweep_op%0d", i), sweep_exp[i], 1'b0);
    end

    // zero and wrap
    do_op(4'd5, 8'h47, 8'h47);  check_lit("sub_self", 8'h00, 1'b1);
    do_op(4'd4, 8'hFF, 8'h01);  check_lit("add_wrap", 8'h00, 1'b1);
    do_op(4'd5, 8'h00, 8'h01);  check_lit("sub_wrap", 8'hFF, 1'b0);

    // rotate
    do_op(4'd9, 8'h47, 8'd12);  check_lit("rol12", 8'b01110100, 1'b0);
    do_op(4'd9, 8'h47, 8'd8);   check_lit("rol8", 8'h47, 1'b0);
    do_op(4'd9, 8'h47, 8'd0);   check_lit("rol0", 8'h47, 1'b0);

    // shift and multiply boundaries
    do_op(4'd6, 8'h47, 8'd8);   check_lit("slr8", 8'h00, 1'b1);
    do_op(4'd7, 8'h47, 8'd200); check_lit("srr200", 8'h00, 1'b1);
    do_op(4'd6, 8'h47, 8'd7);   check_lit("slr7", 8'h80, 1'b0);
    do_op(4'd8, 8'h10, 8'h10);  check_lit("mul_wrap", 8'h00, 1'b1);
    do_op(4'd8, 8'h0F, 8'h11);  check_lit("mul_ff", 8'hFF, 1'b0);

    // reserved codes
    for (int i = 10; i < 16; i++) begin
      do_op(i[3:0], 8'hAA, 8'hAA);
      check_lit($sformatf("reserved%0d", i), 8'h00, 1'b1);
    end

    // hold between edges
    do_op(4'd2, 8'h30, 8'h03);
    check_lit("hold_before", 8'h33, 1'b0);
    held = S;
    #2;
    Seletor = 4'd0;
    A = 8'h00;
    B = 8'h55;
    #1;
    check_lit("hold_after_change", held, 1'b0);
    @(negedge clk);
    check_lit("hold_next_edge", 8'hFF, 1'b0);

    // mid-stream reset, then recovery
    rst_n = 1'b0;
    do_op(4'd3, 8'h0F, 8'hF0);  check_lit("mid_reset", 8'h00, 1'b1);
    rst_n = 1'b1;
    do_op(4'd3, 8'h0F, 8'hF0);  check_lit("mid_release", 8'hFF, 1'b0);

    // randomized traffic, occasional reset
    for (int n = 0; n < 400; n++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      ra = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) rb = 8'($urandom_range(0, 15));
      else                            rb = 8'($urandom_range(0, 255));
      rst_n = ($urandom_range(0, 24) != 0);
      do_op(4'($urandom_range(0, 15)), ra, rb);
    end
    rst_n = 1'b1;
    do_op(4'd0, 8'h00, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
